// File: rtl/vmem_pkg.sv
// Shared widths, FSM state encoding and lane/vector types for the vector memory sequencer.
// No logic here; consumers import the whole package.
// Defaults match a 3-lane, 18-bit, 1K-word data memory stage.
package vmem_pkg;

    localparam int AW    = 10;
    localparam int DW    = 18;
    localparam int LANES = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef logic [DW-1:0]     lane_t;
    typedef lane_t [LANES-1:0] vec_t;

endpackage

// File: rtl/vector_mem_seq.sv
// Serialises one LANES-wide vector load/store onto a single-port synchronous RAM, one lane per cycle.
// Latency from accept: read done at +LANES+2, write done at +LANES+1.
// Stall is raised combinationally in the accept cycle and held until DONE; requests in DONE are ignored.
module vector_mem_seq
    import vmem_pkg::*;
#(
    parameter int AW    = vmem_pkg::AW,
    parameter int DW    = vmem_pkg::DW,
    parameter int LANES = vmem_pkg::LANES
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_req_valid,
    input  logic                        i_we,
    input  logic [LANES-1:0][AW-1:0]    i_addr,
    input  logic [LANES-1:0][DW-1:0]    i_wdata,
    output logic [LANES-1:0][DW-1:0]    o_rdata,
    output logic                        o_stall,
    output logic                        o_done,
    output logic [AW-1:0]               o_mem_addr,
    output logic                        o_mem_we,
    output logic [DW-1:0]               o_mem_wdata,
    input  logic [DW-1:0]               i_mem_rdata
);

    // The lane counter is two bits wide, so at most four lanes are supported.
    localparam logic [1:0] K_LAST = 2'(LANES - 1);

    state_t                      r_state;
    logic [1:0]                  r_k;
    logic                        r_we_l;
    logic [LANES-1:0][AW-1:0]    r_addr_l;
    logic [LANES-1:0][DW-1:0]    r_wdata_l;
    logic [LANES-1:0][DW-1:0]    r_rdata;

    logic                        w_in_acc;
    logic                        w_accept;

    assign w_in_acc = (r_state == S_ACC);
    assign w_accept = (r_state == S_IDLE) && i_req_valid;

    // FSM, lane counter, request latch and read-data capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_k       <= 2'd0;
            r_we_l    <= 1'b0;
            r_addr_l  <= '0;
            r_wdata_l <= '0;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_we_l    <= i_we;
                        r_addr_l  <= i_addr;
                        r_wdata_l <= i_wdata;
                        r_k       <= 2'd0;
                        r_state   <= S_ACC;
                    end
                end
                S_ACC: begin
                    // RAM returns the previous lane's word this cycle.
                    if (!r_we_l && (r_k != 2'd0)) begin
                        r_rdata[r_k - 2'd1] <= i_mem_rdata;
                    end
                    r_k <= r_k + 2'd1;
                    if (r_k == K_LAST) begin
                        r_state <= r_we_l ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Last lane's word arrives one cycle after its address.
                    r_rdata[LANES-1] <= i_mem_rdata;
                    r_state          <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // RAM port is active only in ACC and parks at zero otherwise.
    always_comb begin
        o_mem_we    = w_in_acc && r_we_l;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_in_acc) begin
            o_mem_addr  = r_addr_l[r_k];
            o_mem_wdata = r_wdata_l[r_k];
        end
    end

    // Stall covers the accept cycle combinationally; reset forces it low even with a request pending.
    assign o_stall = i_rst_n && (w_accept || w_in_acc || (r_state == S_WAIT));
    assign o_done  = (r_state == S_DONE);
    assign o_rdata = r_rdata;

endmodule

// File: tb/tb_vector_mem_seq.sv
// Testbench for vector_mem_seq: behavioural 1-cycle RAM, table of vector accesses with a scoreboard,
// plus directed sequences for back-to-back requests and mid-write reset.
// All expected values come from the table constants and bench-side bookkeeping.
module tb_vector_mem_seq;

    localparam int AW = 10;
    localparam int DW = 18;
    localparam int LN = 3;

    typedef struct {
        logic                 we;
        logic [LN-1:0][AW-1:0] addr;
        logic [LN-1:0][DW-1:0] wdata;
        logic [LN-1:0][DW-1:0] exp_rdata;
    } vec_rec_t;

    typedef struct {
        logic [LN-1:0][DW-1:0] rdata;
        int                    lat;
    } exp_t;

    logic                  clk;
    logic                  rst_n;
    logic                  req_valid;
    logic                  we;
    logic [LN-1:0][AW-1:0] addr;
    logic [LN-1:0][DW-1:0] wdata;
    logic [LN-1:0][DW-1:0] rdata;
    logic                  stall;
    logic                  done;
    logic [AW-1:0]         mem_addr;
    logic                  mem_we;
    logic [DW-1:0]         mem_wdata;
    logic [DW-1:0]         mem_rdata;

    logic [DW-1:0]         ram [0:(1<<AW)-1];
    logic                  pre_we;
    logic [AW-1:0]         pre_addr;
    logic [DW-1:0]         pre_dat;

    int n_vec;
    int n_miss;
    exp_t sb[$];
    vec_rec_t tbl[8];

    vector_mem_seq #(.AW(AW), .DW(DW), .LANES(LN)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_we        (we),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_rdata     (rdata),
        .o_stall     (stall),
        .o_done      (done),
        .o_mem_addr  (mem_addr),
        .o_mem_we    (mem_we),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM with a bench-side preload port.
    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_dat;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ram_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_dat  = d;
        tick();
        pre_we   = 1'b0;
    endtask

    function automatic vec_rec_t mk(input logic w,
                                    input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                    input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                    input logic [DW-1:0] r0, input logic [DW-1:0] r1, input logic [DW-1:0] r2);
        vec_rec_t v;
        v.we = w;
        v.addr[0] = a0;  v.addr[1] = a1;  v.addr[2] = a2;
        v.wdata[0] = d0; v.wdata[1] = d1; v.wdata[2] = d2;
        v.exp_rdata[0] = r0; v.exp_rdata[1] = r1; v.exp_rdata[2] = r2;
        return v;
    endfunction

    // Issue one request at the current negedge and follow it to its done pulse.
    task automatic do_req(input string tag, input vec_rec_t v);
        exp_t e;
        exp_t got;
        int   cyc;
        e.rdata = v.exp_rdata;
        e.lat   = v.we ? 4 : 5;
        sb.push_back(e);
        req_valid = 1'b1;
        we        = v.we;
        addr      = v.addr;
        wdata     = v.wdata;
        #1;
        chk({tag, " accept stall"}, 32'(stall), 32'd1);
        for (int l = 0; l < LN; l++) begin
            tick();
            if (l == 0) begin
                // Post-accept input changes must have no effect.
                req_valid = 1'b0;
                we        = ~v.we;
                addr      = '{default: 10'd99};
                wdata     = '{default: 18'h3ABCD};
            end
            #1;
            chk($sformatf("%s lane%0d mem_addr", tag, l), 32'(mem_addr), 32'(v.addr[l]));
            chk($sformatf("%s lane%0d mem_we", tag, l), 32'(mem_we), 32'(v.we));
            chk($sformatf("%s lane%0d mem_wdata", tag, l), 32'(mem_wdata), 32'(v.wdata[l]));
            chk($sformatf("%s lane%0d stall", tag, l), 32'(stall), 32'd1);
        end
        cyc = 3;
        while (!done && cyc < 12) begin
            tick();
            #1;
            cyc++;
            if (!done) chk($sformatf("%s wait stall c%0d", tag, cyc), 32'(stall), 32'd1);
        end
        got = sb.pop_front();
        chk({tag, " latency"}, 32'(cyc), 32'(got.lat));
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " done stall"}, 32'(stall), 32'd0);
        chk({tag, " done mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, " done mem_addr"}, 32'(mem_addr), 32'd0);
        for (int l = 0; l < LN; l++)
            chk($sformatf("%s rdata%0d", tag, l), 32'(rdata[l]), 32'(got.rdata[l]));
        tick();
        #1;
        chk({tag, " done pulse width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int ndone;
        int first_done;
        int last_done;
        vec_rec_t v;

        n_vec = 0;
        n_miss = 0;
        pre_we = 1'b0;
        pre_addr = '0;
        pre_dat = '0;
        rst_n = 1'b0;
        req_valid = 1'b1;
        we = 1'b1;
        addr = '0;
        wdata = '0;

        tbl[0] = mk(1'b0, 10'd5, 10'd6, 10'd4, 18'h0, 18'h0, 18'h0, 18'h00011, 18'h00022, 18'h00033);
        tbl[1] = mk(1'b1, 10'd10, 10'd11, 10'd9, 18'd1, 18'd2, 18'd3, 18'h00011, 18'h00022, 18'h00033);
        tbl[2] = mk(1'b0, 10'd10, 10'd11, 10'd9, 18'h0, 18'h0, 18'h0, 18'd1, 18'd2, 18'd3);
        tbl[3] = mk(1'b1, 10'd7, 10'd7, 10'd7, 18'hA, 18'hB, 18'hC, 18'd1, 18'd2, 18'd3);
        tbl[4] = mk(1'b0, 10'd7, 10'd7, 10'd7, 18'h0, 18'h0, 18'h0, 18'hC, 18'hC, 18'hC);
        tbl[5] = mk(1'b1, 10'd1023, 10'd0, 10'd1022, 18'h3FFFF, 18'h00155, 18'h002AA, 18'hC, 18'hC, 18'hC);
        tbl[6] = mk(1'b0, 10'd1023, 10'd0, 10'd1022, 18'h0, 18'h0, 18'h0, 18'h3FFFF, 18'h00155, 18'h002AA);
        tbl[7] = mk(1'b0, 10'd4, 10'd5, 10'd6, 18'h0, 18'h0, 18'h0, 18'h00033, 18'h00011, 18'h00022);

        // Reset state with a request pending.
        tick();
        #1;
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'd0);
        chk("rst mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst rdata", 32'(rdata[0] | rdata[1] | rdata[2]), 32'd0);
        req_valid = 1'b0;
        tick();
        rst_n = 1'b1;

        ram_wr(10'd5, 18'h00011);
        ram_wr(10'd6, 18'h00022);
        ram_wr(10'd4, 18'h00033);
        for (int a = 20; a < 23; a++) ram_wr(10'(a), 18'h0);

        // Idle without a request: no stall, no RAM activity.
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            chk($sformatf("idle stall c%0d", c), 32'(stall), 32'd0);
            chk($sformatf("idle mem_we c%0d", c), 32'(mem_we), 32'd0);
            chk($sformatf("idle mem_addr c%0d", c), 32'(mem_addr), 32'd0);
        end
        @(negedge clk);

        for (int i = 0; i < 8; i++) do_req($sformatf("vec%0d", i), tbl[i]);
        chk("dup ram[7]", 32'(ram[7]), 32'hC);
        chk("wrap ram[1023]", 32'(ram[1023]), 32'h3FFFF);
        chk("wrap ram[0]", 32'(ram[0]), 32'h155);

        // Back-to-back: request held high through DONE.
        ndone = 0;
        first_done = -1;
        last_done = -1;
        req_valid = 1'b1;
        we = 1'b0;
        addr = tbl[0].addr;
        wdata = '0;
        for (int c = 0; c < 15; c++) begin
            #1;
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = c;
                last_done = c;
            end
            if (c == 5) chk("b2b stall in DONE", 32'(stall), 32'd0);
            if (c == 6) chk("b2b re-accept stall", 32'(stall), 32'd1);
            if (c == 11) req_valid = 1'b0;
            tick();
        end
        chk("b2b done count", 32'(ndone), 32'd2);
        chk("b2b first done", 32'(first_done), 32'd5);
        chk("b2b second done", 32'(last_done), 32'd11);
        chk("b2b rdata0", 32'(rdata[0]), 32'h00011);
        chk("b2b rdata2", 32'(rdata[2]), 32'h00033);

        // Reset in the middle of a write, during the second lane cycle.
        req_valid = 1'b1;
        we = 1'b1;
        addr[0] = 10'd20; addr[1] = 10'd21; addr[2] = 10'd22;
        wdata[0] = 18'h100; wdata[1] = 18'h200; wdata[2] = 18'h300;
        tick();
        req_valid = 1'b0;
        tick();
        #1;
        chk("rstw pre mem_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstw mem_we", 32'(mem_we), 32'd0);
        chk("rstw mem_addr", 32'(mem_addr), 32'd0);
        chk("rstw mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rstw stall", 32'(stall), 32'd0);
        chk("rstw done", 32'(done), 32'd0);
        chk("rstw rdata", 32'(rdata[0] | rdata[1] | rdata[2]), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rstw ram[20] kept", 32'(ram[20]), 32'h100);
        chk("rstw ram[22] untouched", 32'(ram[22]), 32'h0);

        // Recovery after reset.
        v = tbl[2];
        v.exp_rdata[0] = 18'd1; v.exp_rdata[1] = 18'd2; v.exp_rdata[2] = 18'd3;
        do_req("post-reset read", v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
